// File: rtl/lcd_pkg.sv
// Shared constants and encodings for the 2x16 LCD character arbiter.
package lcd_pkg;

    localparam int LCD_CELLS  = 32;
    localparam int ROW2_BASE  = 16;
    localparam int CELL_IDX_W = $clog2(LCD_CELLS);
    localparam int CHAR_W     = 8;
    localparam int FRAME_W    = LCD_CELLS * CHAR_W;

    localparam logic [CHAR_W-1:0] BLANK_CHAR_DEF = 8'h20;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/lcd_char_arbiter_if.sv
// Requester, clear and frame signals of the LCD character arbiter.
// clr_req exists only when LCD_ARB_CLEAR_EN is defined.
interface lcd_char_arbiter_if;

    logic                                  a_valid;
    logic [lcd_pkg::CELL_IDX_W-1:0]        a_addr;
    logic [lcd_pkg::CHAR_W-1:0]            a_char;
    logic                                  a_ready;
    logic                                  b_valid;
    logic [lcd_pkg::CELL_IDX_W-1:0]        b_addr;
    logic [lcd_pkg::CHAR_W-1:0]            b_char;
    logic                                  b_ready;
`ifdef LCD_ARB_CLEAR_EN
    logic                                  clr_req;
`endif
    logic [lcd_pkg::FRAME_W-1:0]           char_out;
    logic                                  busy;
    logic                                  wr_pulse;

    modport master (
`ifdef LCD_ARB_CLEAR_EN
        output clr_req,
`endif
        output a_valid, a_addr, a_char,
        output b_valid, b_addr, b_char,
        input  a_ready, b_ready,
        input  char_out, busy, wr_pulse
    );

    modport slave (
`ifdef LCD_ARB_CLEAR_EN
        input  clr_req,
`endif
        input  a_valid, a_addr, a_char,
        input  b_valid, b_addr, b_char,
        output a_ready, b_ready,
        output char_out, busy, wr_pulse
    );

endinterface

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin grant with last_grant history; grants are combinational,
// history advances only on an accepted write.
module lcd_rr_arb2
    import lcd_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_grant,
    output logic b_grant
);

    grant_e last_grant;

    // On a tie the requester that did not win last time goes first.
    assign a_grant = en && a_valid && (!b_valid || (last_grant == GRANT_B));
    assign b_grant = en && b_valid && (!a_valid || (last_grant == GRANT_A));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_B;
        end else if (a_grant) begin
            last_grant <= GRANT_A;
        end else if (b_grant) begin
            last_grant <= GRANT_B;
        end
    end

endmodule

// File: rtl/lcd_char_arbiter.sv
// 32-cell LCD character buffer shared by two round-robin requesters.
// Optional whole-buffer clear sweep is built when LCD_ARB_CLEAR_EN is defined.
module lcd_char_arbiter
    import lcd_pkg::*;
#(
    parameter logic [CHAR_W-1:0] BLANK_CHAR    = BLANK_CHAR_DEF,
    parameter int                CLR_ROW_SPLIT = ROW2_BASE
) (
    input  logic           clk,
    input  logic           reset,
    lcd_char_arbiter_if.slave bus
);

    if (CLR_ROW_SPLIT < 1 || CLR_ROW_SPLIT >= LCD_CELLS) begin : g_bad_split
        $error("CLR_ROW_SPLIT must lie inside the cell range");
    end

    arb_state_e                       state;
    logic [LCD_CELLS-1:0][CHAR_W-1:0] cells;
    logic                             wr_pulse_q;
    logic                             arb_en;
    logic                             a_grant;
    logic                             b_grant;
    logic [CELL_IDX_W-1:0]            wr_addr;
    logic [CHAR_W-1:0]                wr_char;

`ifdef LCD_ARB_CLEAR_EN
    logic                  busy_q;
    logic [CELL_IDX_W-1:0] clr_idx;
    logic                  clr_start;

    assign clr_start = (state == ARB) && bus.clr_req;
    assign arb_en    = !reset && (state == ARB) && !bus.clr_req;
    assign bus.busy  = busy_q;
`else
    assign arb_en    = !reset && (state == ARB);
    assign bus.busy  = 1'b0;
`endif

    lcd_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .a_valid (bus.a_valid),
        .b_valid (bus.b_valid),
        .a_grant (a_grant),
        .b_grant (b_grant)
    );

    assign bus.a_ready  = a_grant;
    assign bus.b_ready  = b_grant;
    assign wr_addr      = a_grant ? bus.a_addr : bus.b_addr;
    assign wr_char      = a_grant ? bus.a_char : bus.b_char;
    assign bus.char_out = cells;
    assign bus.wr_pulse = wr_pulse_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the cell buffer is a register file, not a RAM, so every cell
            // is reset to BLANK_CHAR; a memory macro could not be cleared this way.
            cells      <= {LCD_CELLS{BLANK_CHAR}};
            state      <= ARB;
            wr_pulse_q <= 1'b0;
`ifdef LCD_ARB_CLEAR_EN
            busy_q     <= 1'b0;
            clr_idx    <= '0;
`endif
        end else begin
            wr_pulse_q <= 1'b0;
            unique case (state)
                ARB: begin
`ifdef LCD_ARB_CLEAR_EN
                    if (clr_start) begin
                        state   <= CLEAR;
                        busy_q  <= 1'b1;
                        clr_idx <= '0;
                    end else
`endif
                    if (a_grant || b_grant) begin
                        cells[wr_addr] <= wr_char;
                        wr_pulse_q     <= 1'b1;
                    end
                end
`ifdef LCD_ARB_CLEAR_EN
                CLEAR: begin
                    cells[clr_idx] <= BLANK_CHAR;
                    // The sweep reports completion once, after the last cell.
                    if (clr_idx == CELL_IDX_W'(LCD_CELLS - 1)) begin
                        state      <= ARB;
                        busy_q     <= 1'b0;
                        wr_pulse_q <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
`endif
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// Directed self-checking bench for lcd_char_arbiter; clear-sweep vectors are
// compiled in only when LCD_ARB_CLEAR_EN is defined.
module tb_lcd_char_arbiter;
    import lcd_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_char_arbiter_if bus ();

    lcd_char_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [FRAME_W-1:0] exp_frame;

    localparam logic [FRAME_W-1:0] ALL_BLANK = {32{8'h20}};

    task automatic check(input string tag, input logic [FRAME_W-1:0] got,
                         input logic [FRAME_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [7:0] ac,
                         input logic bv, input logic [4:0] ba, input logic [7:0] bc);
        bus.a_valid = av; bus.a_addr = aa; bus.a_char = ac;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_char = bc;
    endtask

    // Single-requester write: ready is checked in the request cycle, the cell
    // and wr_pulse in the following one.
    task automatic write_one(input string tag, input logic use_a,
                             input logic [4:0] addr, input logic [7:0] ch);
        if (use_a) drive(1'b1, addr, ch, 1'b0, 5'd9, 8'hEE);
        else       drive(1'b0, 5'd9, 8'hEE, 1'b1, addr, ch);
        #1;
        check({tag, "_a_ready"}, FRAME_W'(bus.a_ready), FRAME_W'(use_a));
        check({tag, "_b_ready"}, FRAME_W'(bus.b_ready), FRAME_W'(!use_a));
        tick();
        exp_frame[addr*8 +: 8] = ch;
        check({tag, "_frame"}, bus.char_out, exp_frame);
        check({tag, "_wr_pulse"}, FRAME_W'(bus.wr_pulse), FRAME_W'(1'b1));
    endtask

    // Four tie cycles, A at cell 0 with 'X', B at cell 31 with 'Y'.
    task automatic tie_run(input string tag, input logic a_first);
        logic exp_a;
        for (int i = 0; i < 4; i++) begin
            exp_a = a_first ^ logic'(i % 2);
            drive(1'b1, 5'd0, 8'h58, 1'b1, 5'd31, 8'h59);
            #1;
            check($sformatf("%s%0d_a_ready", tag, i), FRAME_W'(bus.a_ready), FRAME_W'(exp_a));
            check($sformatf("%s%0d_b_ready", tag, i), FRAME_W'(bus.b_ready), FRAME_W'(!exp_a));
            tick();
            check($sformatf("%s%0d_wr_pulse", tag, i), FRAME_W'(bus.wr_pulse), FRAME_W'(1'b1));
        end
        exp_frame[7:0]     = 8'h58;
        exp_frame[255:248] = 8'h59;
        check({tag, "_frame"}, bus.char_out, exp_frame);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 5'd3, 8'h33, 1'b1, 5'd4, 8'h34);
`ifdef LCD_ARB_CLEAR_EN
        bus.clr_req = 1'b0;
`endif
        #1;
        check("rst_a_ready", FRAME_W'(bus.a_ready), '0);
        check("rst_b_ready", FRAME_W'(bus.b_ready), '0);
        tick();
        tick();
        check("rst_frame", bus.char_out, ALL_BLANK);
        check("rst_busy", FRAME_W'(bus.busy), '0);
        check("rst_wr_pulse", FRAME_W'(bus.wr_pulse), '0);
        reset = 1'b0;
        drive(1'b0, 5'd7, 8'h37, 1'b0, 5'd8, 8'h38);
        exp_frame = ALL_BLANK;
        #1;
        check("idle_a_ready", FRAME_W'(bus.a_ready), '0);
        check("idle_b_ready", FRAME_W'(bus.b_ready), '0);
        tick();
        check("idle_frame", bus.char_out, ALL_BLANK);
        check("idle_wr_pulse", FRAME_W'(bus.wr_pulse), '0);

        write_one("a_only", 1'b1, 5'd5, 8'h41);
        check("a_only_cell5", FRAME_W'(bus.char_out[47:40]), FRAME_W'(8'h41));
        drive(1'b0, 5'd5, 8'h00, 1'b0, 5'd6, 8'h00);
        tick();
        check("pulse_drop", FRAME_W'(bus.wr_pulse), '0);
        check("no_write_frame", bus.char_out, exp_frame);

        write_one("b_only", 1'b0, 5'd20, 8'h62);
        tie_run("tie_ab", 1'b1);

        write_one("a_last", 1'b1, 5'd16, 8'h51);
        // An idle cycle must not move the round-robin pointer.
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
        tick();
        tie_run("tie_ba", 1'b0);
        check("busy_quiet", FRAME_W'(bus.busy), '0);

        reset = 1'b1;
        drive(1'b1, 5'd2, 8'h32, 1'b1, 5'd3, 8'h33);
        #1;
        check("rst2_a_ready", FRAME_W'(bus.a_ready), '0);
        check("rst2_b_ready", FRAME_W'(bus.b_ready), '0);
        tick();
        reset = 1'b0;
        exp_frame = ALL_BLANK;
        check("rst2_frame", bus.char_out, ALL_BLANK);
        check("rst2_wr_pulse", FRAME_W'(bus.wr_pulse), '0);
        tie_run("tie_post_rst", 1'b1);

`ifdef LCD_ARB_CLEAR_EN
        begin
            int busy_n  = 0;
            int ready_n = 0;
            for (int i = 0; i < LCD_CELLS; i++) begin
                drive(1'b1, 5'(i), 8'h5A, 1'b0, 5'd0, 8'h00);
                tick();
            end
            exp_frame = {32{8'h5A}};
            check("fill_frame", bus.char_out, exp_frame);

            drive(1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 8'h4B);
            bus.clr_req = 1'b1;
            #1;
            check("clr_b_ready", FRAME_W'(bus.b_ready), '0);
            check("clr_a_ready", FRAME_W'(bus.a_ready), '0);
            tick();
            for (int c = 1; c <= LCD_CELLS; c++) begin
                bus.clr_req = (c == 5);
                #1;
                if (bus.busy === 1'b1) busy_n++;
                if (bus.b_ready !== 1'b0) ready_n++;
                if (bus.wr_pulse !== 1'b0) ready_n++;
                tick();
            end
            bus.clr_req = 1'b0;
            check("sweep_busy_cycles", FRAME_W'(busy_n), FRAME_W'(32));
            check("sweep_ready_or_pulse", FRAME_W'(ready_n), '0);
            #1;
            exp_frame = ALL_BLANK;
            check("sweep_done_busy", FRAME_W'(bus.busy), '0);
            check("sweep_done_pulse", FRAME_W'(bus.wr_pulse), FRAME_W'(1'b1));
            check("sweep_done_frame", bus.char_out, ALL_BLANK);
            check("sweep_b_ready", FRAME_W'(bus.b_ready), FRAME_W'(1'b1));
            tick();
            exp_frame[7*8 +: 8] = 8'h4B;
            check("sweep_b_write", bus.char_out, exp_frame);

            write_one("pre_abort", 1'b1, 5'd30, 8'h52);
            drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
            bus.clr_req = 1'b1;
            tick();
            bus.clr_req = 1'b0;
            for (int c = 0; c < 10; c++) tick();
            check("abort_busy_before", FRAME_W'(bus.busy), FRAME_W'(1'b1));
            reset = 1'b1;
            tick();
            reset = 1'b0;
            exp_frame = ALL_BLANK;
            check("abort_busy", FRAME_W'(bus.busy), '0);
            check("abort_frame", bus.char_out, ALL_BLANK);
            check("abort_wr_pulse", FRAME_W'(bus.wr_pulse), '0);
            write_one("abort_arb", 1'b0, 5'd12, 8'h61);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
